// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: decodes the register-write class of the
// instruction leaving MEM, aligns load data, selects the write-back value
// and destination, and stalls MEM while a load waits on data memory.
module mem_wb_pipe_reg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] MEM_Instr,
   input  logic [31:0] MEM_PC,
   input  logic [31:0] MEM_ALU_out,
   input  logic [31:0] MEM_DM_out,
   input  logic        MEM_valid,
   input  logic        MEM_DM_ready,
   input  logic        stall,
   input  logic        flush,
   output logic        MEM_stall_o,
   output logic [31:0] MEM_WB_Instr,
   output logic        MEM_WB_valid,
   output logic        MEM_WB_isW_rd_1,
   output logic        MEM_WB_isW_rt_1,
   output logic        MEM_WB_isW_31_rd_0,
   output logic        MEM_WB_isW_rt_2,
   output logic [4:0]  MEM_WB_dst,
   output logic [31:0] MEM_WB_wdata,
   output logic        MEM_WB_wen
);

   typedef enum logic {RUN = 1'b0, LDWAIT = 1'b1} state_t;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;
   localparam logic [5:0] FN_JALR    = 6'h09;

   // Picks the addressed byte or halfword (little-endian) and extends it.
   // Halfword selection ignores addr[0]; words pass through untouched.
   function automatic logic [31:0] load_align(input logic [5:0]  op,
                                              input logic [1:0]  addr,
                                              input logic [31:0] word);
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      logic [31:0] res;
      case (addr)
         2'd0:    byte_v = word[7:0];
         2'd1:    byte_v = word[15:8];
         2'd2:    byte_v = word[23:16];
         default: byte_v = word[31:24];
      endcase
      half_v = addr[1] ? word[31:16] : word[15:0];
      case (op)
         OP_LB:   res = {{24{byte_v[7]}}, byte_v};
         OP_LBU:  res = {24'd0, byte_v};
         OP_LH:   res = {{16{half_v[15]}}, half_v};
         OP_LHU:  res = {16'd0, half_v};
         default: res = word;
      endcase
      return res;
   endfunction

   logic [5:0] opcode;
   logic [5:0] funct;
   logic [4:0] rt;
   logic [4:0] rd;

   assign opcode = MEM_Instr[31:26];
   assign funct  = MEM_Instr[5:0];
   assign rt     = MEM_Instr[20:16];
   assign rd     = MEM_Instr[15:11];

   logic        w_rd_1, w_rt_1, w_31_rd_0, w_rt_2;
   logic        is_load;
   logic [4:0]  dst_c;
   logic [31:0] wdata_c;
   logic        wen_c;
   logic        ld_pending;

   // Write-class decode, destination and write-back data for the MEM instruction.
   always_comb begin
      w_rd_1    = 1'b0;
      w_rt_1    = 1'b0;
      w_31_rd_0 = 1'b0;
      w_rt_2    = 1'b0;
      dst_c     = 5'd0;
      if (MEM_Instr != 32'd0) begin
         if (opcode == OP_SPECIAL) begin
            if (funct == FN_JALR) begin
               w_31_rd_0 = 1'b1;
               dst_c     = rd;
            end else begin
               case (funct)
                  6'h08, 6'h0C, 6'h0D, 6'h11, 6'h13,
                  6'h18, 6'h19, 6'h1A, 6'h1B: w_rd_1 = 1'b0;
                  default: begin
                     w_rd_1 = 1'b1;
                     dst_c  = rd;
                  end
               endcase
            end
         end else if (opcode == OP_JAL) begin
            w_31_rd_0 = 1'b1;
            dst_c     = 5'd31;
         end else if (opcode[5:3] == 3'b001) begin
            w_rt_1 = 1'b1;
            dst_c  = rt;
         end else if (opcode == OP_LB || opcode == OP_LH || opcode == OP_LW ||
                      opcode == OP_LBU || opcode == OP_LHU) begin
            w_rt_2 = 1'b1;
            dst_c  = rt;
         end
      end
      is_load = w_rt_2;
      if (w_rt_2) begin
         wdata_c = load_align(opcode, MEM_ALU_out[1:0], MEM_DM_out);
      end else if (w_31_rd_0) begin
         wdata_c = MEM_PC + 32'd8;
      end else begin
         wdata_c = MEM_ALU_out;
      end
      wen_c      = MEM_valid & (w_rd_1 | w_rt_1 | w_31_rd_0 | w_rt_2) & (dst_c != 5'd0);
      ld_pending = MEM_valid & is_load & ~MEM_DM_ready;
   end

   // Freeze MEM and upstream while a load waits; never during flush or reset.
   assign MEM_stall_o = rst_n & ~flush & ld_pending;

   state_t state_q, state_d;

   // Load-wait FSM next state: flush aborts, stall holds.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = RUN;
      end else if (!stall) begin
         case (state_q)
            RUN:     if (ld_pending) state_d = LDWAIT;
            LDWAIT:  if (!ld_pending) state_d = RUN;
            default: state_d = RUN;
         endcase
      end
   end

   // Load-wait FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   logic        valid_q,  valid_d;
   logic [31:0] instr_q,  instr_d;
   logic        rd_1_q,   rd_1_d;
   logic        rt_1_q,   rt_1_d;
   logic        l31_q,    l31_d;
   logic        rt_2_q,   rt_2_d;
   logic [4:0]  dst_q,    dst_d;
   logic [31:0] wdata_q,  wdata_d;
   logic        wen_q,    wen_d;

   // Pipeline register next value: flush bubble, stall hold, pending-load bubble, else capture.
   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      rd_1_d  = rd_1_q;
      rt_1_d  = rt_1_q;
      l31_d   = l31_q;
      rt_2_d  = rt_2_q;
      dst_d   = dst_q;
      wdata_d = wdata_q;
      wen_d   = wen_q;
      if (flush || (!stall && ld_pending)) begin
         valid_d = 1'b0;
         instr_d = 32'd0;
         rd_1_d  = 1'b0;
         rt_1_d  = 1'b0;
         l31_d   = 1'b0;
         rt_2_d  = 1'b0;
         dst_d   = 5'd0;
         wdata_d = 32'd0;
         wen_d   = 1'b0;
      end else if (!stall) begin
         valid_d = MEM_valid;
         instr_d = MEM_Instr;
         rd_1_d  = w_rd_1;
         rt_1_d  = w_rt_1;
         l31_d   = w_31_rd_0;
         rt_2_d  = w_rt_2;
         dst_d   = dst_c;
         wdata_d = wdata_c;
         wen_d   = wen_c;
      end
   end

   // MEM/WB register bank with synchronous clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         instr_q <= 32'd0;
         rd_1_q  <= 1'b0;
         rt_1_q  <= 1'b0;
         l31_q   <= 1'b0;
         rt_2_q  <= 1'b0;
         dst_q   <= 5'd0;
         wdata_q <= 32'd0;
         wen_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         rd_1_q  <= rd_1_d;
         rt_1_q  <= rt_1_d;
         l31_q   <= l31_d;
         rt_2_q  <= rt_2_d;
         dst_q   <= dst_d;
         wdata_q <= wdata_d;
         wen_q   <= wen_d;
      end
   end

   assign MEM_WB_valid       = valid_q;
   assign MEM_WB_Instr       = instr_q;
   assign MEM_WB_isW_rd_1    = rd_1_q;
   assign MEM_WB_isW_rt_1    = rt_1_q;
   assign MEM_WB_isW_31_rd_0 = l31_q;
   assign MEM_WB_isW_rt_2    = rt_2_q;
   assign MEM_WB_dst         = dst_q;
   assign MEM_WB_wdata       = wdata_q;
   assign MEM_WB_wen         = wen_q;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed bench for mem_wb_pipe_reg with hand-computed expected values.
module tb_mem_wb_pipe_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] MEM_Instr, MEM_PC, MEM_ALU_out, MEM_DM_out;
   logic        MEM_valid, MEM_DM_ready, stall, flush;
   logic        MEM_stall_o;
   logic [31:0] MEM_WB_Instr;
   logic        MEM_WB_valid;
   logic        MEM_WB_isW_rd_1, MEM_WB_isW_rt_1, MEM_WB_isW_31_rd_0, MEM_WB_isW_rt_2;
   logic [4:0]  MEM_WB_dst;
   logic [31:0] MEM_WB_wdata;
   logic        MEM_WB_wen;

   int n_checks = 0;
   int n_pass   = 0;

   mem_wb_pipe_reg dut (
      .clk(clk), .rst_n(rst_n),
      .MEM_Instr(MEM_Instr), .MEM_PC(MEM_PC), .MEM_ALU_out(MEM_ALU_out),
      .MEM_DM_out(MEM_DM_out), .MEM_valid(MEM_valid), .MEM_DM_ready(MEM_DM_ready),
      .stall(stall), .flush(flush), .MEM_stall_o(MEM_stall_o),
      .MEM_WB_Instr(MEM_WB_Instr), .MEM_WB_valid(MEM_WB_valid),
      .MEM_WB_isW_rd_1(MEM_WB_isW_rd_1), .MEM_WB_isW_rt_1(MEM_WB_isW_rt_1),
      .MEM_WB_isW_31_rd_0(MEM_WB_isW_31_rd_0), .MEM_WB_isW_rt_2(MEM_WB_isW_rt_2),
      .MEM_WB_dst(MEM_WB_dst), .MEM_WB_wdata(MEM_WB_wdata), .MEM_WB_wen(MEM_WB_wen)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
   endtask

   // fl = {isW_rd_1, isW_rt_1, isW_31_rd_0, isW_rt_2}
   task automatic check_wb(input string tag, input logic v, input logic [31:0] ins,
                           input logic [3:0] fl, input logic [4:0] d,
                           input logic [31:0] wd, input logic we);
      check({tag, ".valid"}, {31'd0, MEM_WB_valid}, {31'd0, v});
      check({tag, ".instr"}, MEM_WB_Instr, ins);
      check({tag, ".flags"},
            {28'd0, MEM_WB_isW_rd_1, MEM_WB_isW_rt_1, MEM_WB_isW_31_rd_0, MEM_WB_isW_rt_2},
            {28'd0, fl});
      check({tag, ".dst"}, {27'd0, MEM_WB_dst}, {27'd0, d});
      check({tag, ".wdata"}, MEM_WB_wdata, wd);
      check({tag, ".wen"}, {31'd0, MEM_WB_wen}, {31'd0, we});
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] dm, input logic v, input logic rdy);
      MEM_Instr    = ins;
      MEM_PC       = pc;
      MEM_ALU_out  = alu;
      MEM_DM_out   = dm;
      MEM_valid    = v;
      MEM_DM_ready = rdy;
      #1;
   endtask

   task automatic check_stall(input string tag, input logic exp_v);
      check(tag, {31'd0, MEM_stall_o}, {31'd0, exp_v});
   endtask

   localparam logic [31:0] ADDU = 32'h0022_1821;
   localparam logic [31:0] LB5  = 32'h8005_0002;
   localparam logic [31:0] LBU5 = 32'h9005_0002;
   localparam logic [31:0] LH7  = 32'h8407_0000;
   localparam logic [31:0] LHU7 = 32'h9407_0000;
   localparam logic [31:0] LW6  = 32'h8C06_0000;
   localparam logic [31:0] JAL  = 32'h0C00_0040;
   localparam logic [31:0] JALR0= 32'h0020_0009;
   localparam logic [31:0] ORI4 = 32'h3404_0007;
   localparam logic [31:0] MULT = 32'h0022_0018;

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      cyc(); cyc();
      // Pending load presented during reset: stall output must stay low.
      drive(LW6, 32'h0, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b0);
      check_stall("rst_stall", 1'b0);
      cyc();
      check_wb("reset", 1'b0, 32'd0, 4'b0000, 5'd0, 32'd0, 1'b0);

      rst_n = 1'b1;
      drive(ADDU, 32'h0040_0000, 32'h10, 32'h0, 1'b1, 1'b1);
      check_stall("addu_stall", 1'b0);
      cyc();
      check_wb("addu", 1'b1, ADDU, 4'b1000, 5'd3, 32'h10, 1'b1);

      drive(LB5, 32'h0, 32'h2, 32'h1180_2233, 1'b1, 1'b1);
      cyc();
      check_wb("lb", 1'b1, LB5, 4'b0001, 5'd5, 32'hFFFF_FF80, 1'b1);

      drive(LBU5, 32'h0, 32'h2, 32'h1180_2233, 1'b1, 1'b1);
      cyc();
      check("lbu.wdata", MEM_WB_wdata, 32'h0000_0080);

      drive(LH7, 32'h0, 32'h3, 32'h1180_2233, 1'b1, 1'b1);
      cyc();
      check("lh_hi.wdata", MEM_WB_wdata, 32'h0000_1180);

      drive(LH7, 32'h0, 32'h1, 32'h0000_8001, 1'b1, 1'b1);
      cyc();
      check("lh_lo.wdata", MEM_WB_wdata, 32'hFFFF_8001);

      drive(LHU7, 32'h0, 32'h0, 32'h0000_8001, 1'b1, 1'b1);
      cyc();
      check("lhu.wdata", MEM_WB_wdata, 32'h0000_8001);

      // LW waits three cycles on data memory.
      drive(LW6, 32'h0, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check_stall($sformatf("lw_wait%0d_stall", i), 1'b1);
         cyc();
         check_wb($sformatf("lw_wait%0d", i), 1'b0, 32'd0, 4'b0000, 5'd0, 32'd0, 1'b0);
      end
      MEM_DM_ready = 1'b1; #1;
      check_stall("lw_ready_stall", 1'b0);
      cyc();
      check_wb("lw_done", 1'b1, LW6, 4'b0001, 5'd6, 32'hDEAD_BEEF, 1'b1);

      drive(JAL, 32'h0040_0010, 32'h0, 32'h0, 1'b1, 1'b1);
      cyc();
      check_wb("jal", 1'b1, JAL, 4'b0010, 5'd31, 32'h0040_0018, 1'b1);

      drive(JALR0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 1'b1);
      cyc();
      check_wb("jalr0", 1'b1, JALR0, 4'b0010, 5'd0, 32'h0000_0004, 1'b0);

      drive(MULT, 32'h0, 32'h55, 32'h0, 1'b1, 1'b1);
      cyc();
      check_wb("mult", 1'b1, MULT, 4'b0000, 5'd0, 32'h55, 1'b0);

      drive(32'd0, 32'h0, 32'h66, 32'h0, 1'b1, 1'b1);
      cyc();
      check_wb("nop", 1'b1, 32'd0, 4'b0000, 5'd0, 32'h66, 1'b0);

      // Flush during load wait.
      drive(LW6, 32'h0, 32'h100, 32'h1234_5678, 1'b1, 1'b0);
      cyc();
      check_wb("lw2_wait", 1'b0, 32'd0, 4'b0000, 5'd0, 32'd0, 1'b0);
      flush = 1'b1; #1;
      check_stall("flush_stall", 1'b0);
      cyc();
      check_wb("flush", 1'b0, 32'd0, 4'b0000, 5'd0, 32'd0, 1'b0);
      flush = 1'b0;
      drive(ORI4, 32'h0, 32'h7, 32'h0, 1'b1, 1'b1);
      check_stall("ori_stall", 1'b0);
      cyc();
      check_wb("ori", 1'b1, ORI4, 4'b0100, 5'd4, 32'h7, 1'b1);

      // Stall holds contents, including wen.
      drive(ADDU, 32'h0, 32'h99, 32'h0, 1'b1, 1'b1);
      cyc();
      stall = 1'b1;
      drive(LW6, 32'h0, 32'h100, 32'h0, 1'b1, 1'b0);
      check_stall("stall_ld_stall", 1'b1);
      cyc();
      check_wb("stall_hold", 1'b1, ADDU, 4'b1000, 5'd3, 32'h99, 1'b1);
      cyc();
      check_wb("stall_hold2", 1'b1, ADDU, 4'b1000, 5'd3, 32'h99, 1'b1);

      // Reset mid-stream while stalled clears everything.
      rst_n = 1'b0; #1;
      check_stall("rst2_stall", 1'b0);
      cyc();
      check_wb("rst_stall", 1'b0, 32'd0, 4'b0000, 5'd0, 32'd0, 1'b0);
      rst_n = 1'b1; stall = 1'b0;
      drive(ORI4, 32'h0, 32'h7, 32'h0, 1'b1, 1'b1);
      cyc();
      check_wb("post_rst", 1'b1, ORI4, 4'b0100, 5'd4, 32'h7, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_wb_pipe_reg.md
# mem_wb_pipe_reg

MEM/WB pipeline register for the 48-instruction MIPS core. It captures the instruction leaving the MEM stage and decodes its register-write class into the `MEM_WB_isW_*` flags consumed by the EX/MEM and ID/EX forwarding units. It aligns load data and selects the write-back value and destination. It also stalls the MEM stage while a load waits on data memory.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `MEM_Instr` in 32: instruction in MEM.
- `MEM_PC` in 32: PC of the instruction in MEM.
- `MEM_ALU_out` in 32: ALU result, which is also the data address for loads.
- `MEM_DM_out` in 32: raw word read from data memory.
- `MEM_valid` in 1: MEM holds a real instruction.
- `MEM_DM_ready` in 1: `MEM_DM_out` is valid this cycle.
- `stall` in 1: hazard unit hold request.
- `flush` in 1: exception/redirect kill.
- `MEM_stall_o` out 1: freeze MEM and all upstream stages.
- `MEM_WB_Instr` out 32: registered instruction.
- `MEM_WB_valid` out 1: registered valid.
- `MEM_WB_isW_rd_1` out 1: R-type ALU op writing rd.
- `MEM_WB_isW_rt_1` out 1: I-type ALU op writing rt.
- `MEM_WB_isW_31_rd_0` out 1: JAL or JALR link write.
- `MEM_WB_isW_rt_2` out 1: load writing rt.
- `MEM_WB_dst` out 5: destination register.
- `MEM_WB_wdata` out 32: write-back data.
- `MEM_WB_wen` out 1: register-file write enable.

## Operation
- Write-class decode is combinational on `MEM_Instr` and registered. At most one flag is set. All flags are 0 when `MEM_Instr==0`.
  - `isW_rd_1`: opcode 0x00 and funct not in {0x08 JR, 0x09 JALR, 0x0C, 0x0D, 0x11, 0x13, 0x18–0x1B}. This class includes the shifts, the ALU ops, MFHI (0x10) and MFLO (0x12).
  - `isW_rt_1`: opcode 0x08–0x0F.
  - `isW_31_rd_0`: opcode 0x03 (JAL), or opcode 0x00 with funct 0x09 (JALR).
  - `isW_rt_2`: opcode in {0x20 LB, 0x21 LH, 0x23 LW, 0x24 LBU, 0x25 LHU}.
- Destination:
  - rd for `isW_rd_1`.
  - rt for `isW_rt_1` and `isW_rt_2`.
  - 31 for JAL.
  - rd for JALR.
  - 0 for any instruction with no write class.
- `MEM_WB_wen` = valid & (any flag) & (dst≠0).
- Write data:
  - Loads: byte or halfword taken from `MEM_DM_out` at lane `MEM_ALU_out[1:0]`, little-endian. LB and LH sign-extend; LBU and LHU zero-extend. For LH/LHU, `addr[0]` is ignored.
  - Links: `MEM_PC+8`, modulo 2^32.
  - Otherwise: `MEM_ALU_out`.
- FSM with states RUN and LDWAIT:
  - RUN → LDWAIT when `MEM_valid`, the instruction is a load, `!MEM_DM_ready`, and `!stall`.
  - LDWAIT → RUN on the cycle `MEM_DM_ready=1`. The load is captured in that same cycle.
  - flush forces RUN.
- `MEM_stall_o` = `MEM_valid` & load & `!MEM_DM_ready` (combinational). It is independent of state and 0 when flush=1.
- Per-edge priority, highest first:
  1. `!rst_n`: clear.
  2. flush: load a bubble.
  3. stall: hold all registers.
  4. Load pending with `!MEM_DM_ready`: load a bubble.
  5. Otherwise: capture.
- A bubble means valid=0, Instr=0, all flags=0, dst=0, wdata=0, wen=0.

## Timing
- Reset values: all outputs 0, state RUN. `MEM_stall_o` is 0 while in reset.
- Latency: one cycle from MEM inputs to `MEM_WB_*`.
- Hold under `stall` keeps wen asserted. The repeated register-file write is idempotent, and this behaviour is required.
- A load waiting N cycles causes N bubble cycles at WB, then the load appears one cycle after `MEM_DM_ready` rises.
- If `MEM_DM_ready` is already 1 on a load's first cycle, the load has zero wait and is captured like any other instruction.
- Flush during LDWAIT aborts the load: a bubble is loaded and `MEM_stall_o` drops in the same cycle.
- Reset mid-LDWAIT: the next cycle is in RUN with outputs 0.
- When stall and a pending load coincide, stall wins. The state does not advance and `MEM_stall_o` still follows its combinational equation.

## Test plan
- ADDU $3,$1,$2 (0x00221821) with ALU_out=0x10 → next cycle:
  - `isW_rd_1`=1, dst=3, wdata=0x10, wen=1.
- LB $5,2($0) (opcode 0x20, rt=5), ALU_out=2, DM_out=0x11_80_22_33, DM_ready=1:
  - wdata=0xFFFFFF80, `isW_rt_2`=1.
  - Same case as LBU gives wdata=0x00000080.
- LW with DM_ready low for 3 cycles:
  - `MEM_stall_o`=1 for exactly 3 cycles.
  - WB shows 3 bubbles.
  - WB then holds the load with `valid`=1 in the cycle after `MEM_DM_ready` rises.
- JAL (0x0C000040) at PC 0x00400010:
  - `isW_31_rd_0`=1, dst=31, wdata=0x00400018.
  - JALR rd=0 gives wen=0.
- flush asserted during LDWAIT:
  - Bubble loaded.
  - `MEM_stall_o`=0 in the same cycle.
  - State returns to RUN.
  - A following ORI $4,$0,7 is captured normally: `isW_rt_1`=1, wen=1.
- Assert `rst_n`=0 mid-stream with stall=1:
  - All outputs 0 on the next edge.
  - Holding stall during reset does not preserve any prior contents.
